// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned DEF_NUM_REGS = 32;

  // Upper bounds used by addr_hit so a single package function serves every
  // parameterisation; narrower callers zero-extend into these widths.
  localparam int unsigned MAX_WRITE  = 4;
  localparam int unsigned MAX_ADDR_W = 16;
  localparam int unsigned WIDX_W     = $clog2(MAX_WRITE);

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0]             reg_data_t;

  typedef struct packed {
    logic              hit;
    logic [WIDX_W-1:0] idx;
  } hit_t;

  // Highest-indexed enabled write port targeting addr wins.
  function automatic hit_t addr_hit(
    input logic [MAX_ADDR_W-1:0]                addr,
    input logic [MAX_WRITE-1:0]                 en_vec,
    input logic [MAX_WRITE-1:0][MAX_ADDR_W-1:0] addr_vec
  );
    hit_t res;
    res = '0;
    for (int unsigned i = 0; i < MAX_WRITE; i++) begin
      if (en_vec[i] && (addr_vec[i] == addr)) begin
        res.hit = 1'b1;
        res.idx = WIDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: zero-register check, write bypass and pending masking.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned ADDR_W   = $clog2(DEF_NUM_REGS),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                   r_addr,
  input  logic [XLEN-1:0]                     stored_data,
  input  logic                                stored_pend,
  input  logic [MAX_WRITE-1:0]                w_en_ext,
  input  logic [MAX_WRITE-1:0][MAX_ADDR_W-1:0] w_addr_ext,
  input  logic [MAX_WRITE-1:0][XLEN-1:0]      w_data_ext,
  input  logic                                rsv_en,
  input  logic [ADDR_W-1:0]                   rsv_addr,
  output logic [XLEN-1:0]                     r_data,
  output logic                                r_pending
);

  hit_t h;
  logic is_zero;

  assign h       = addr_hit(MAX_ADDR_W'(r_addr), w_en_ext, w_addr_ext);
  assign is_zero = (ZERO_REG != 0) && (r_addr == '0);

  // Select read data and pending status with bypass priority over storage.
  always_comb begin
    r_data    = stored_data;
    r_pending = stored_pend;
    if ((BYPASS != 0) && h.hit) begin
      r_data = w_data_ext[h.idx];
      // A same-cycle reservation of this register means a newer producer.
      if (!(rsv_en && (rsv_addr == r_addr))) r_pending = 1'b0;
    end
    if (is_zero) begin
      r_data    = '0;
      r_pending = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with synchronous clear and pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned NUM_WRITE = 1,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic [NUM_READ-1:0][$clog2(NUM_REGS)-1:0]   i_r_addr,
  output logic [NUM_READ-1:0][XLEN-1:0]               o_r_data,
  output logic [NUM_READ-1:0]                         o_r_pending,
  input  logic [NUM_WRITE-1:0]                        i_w_en,
  input  logic [NUM_WRITE-1:0][$clog2(NUM_REGS)-1:0]  i_w_addr,
  input  logic [NUM_WRITE-1:0][XLEN-1:0]              i_w_data,
  input  logic                                        i_rsv_en,
  input  logic [$clog2(NUM_REGS)-1:0]                 i_rsv_addr,
  output logic                                        o_any_pending
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_next;

  logic [MAX_WRITE-1:0]                 w_en_ext;
  logic [MAX_WRITE-1:0][MAX_ADDR_W-1:0] w_addr_ext;
  logic [MAX_WRITE-1:0][XLEN-1:0]       w_data_ext;

  // Widen write ports to the package maxima; unused slots stay disabled.
  always_comb begin
    w_en_ext   = '0;
    w_addr_ext = '0;
    w_data_ext = '0;
    for (int unsigned w = 0; w < NUM_WRITE; w++) begin
      w_en_ext[w]   = i_w_en[w];
      w_addr_ext[w] = MAX_ADDR_W'(i_w_addr[w]);
      w_data_ext[w] = i_w_data[w];
    end
  end

  // Scoreboard next state: writes clear, then a reservation sets (reserve wins).
  always_comb begin
    hit_t h;
    pend_next = pending;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      h = addr_hit(MAX_ADDR_W'(i), w_en_ext, w_addr_ext);
      if (h.hit) pend_next[i] = 1'b0;
    end
    if (i_rsv_en) pend_next[i_rsv_addr] = 1'b1;
    if (ZERO_REG != 0) pend_next[0] = 1'b0;
  end

  // Register array and pending vector; later ports overwrite earlier ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WRITE; w++) begin
        if (i_w_en[w] && !((ZERO_REG != 0) && (i_w_addr[w] == '0)))
          regs[i_w_addr[w]] <= i_w_data[w];
      end
      pending <= pend_next;
    end
  end

  assign o_any_pending = |pending;

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [XLEN-1:0] stored_data;
    logic            stored_pend;

    assign stored_data = regs[i_r_addr[r]];
    assign stored_pend = pending[i_r_addr[r]];

    regfile_read_port #(
      .XLEN     (XLEN),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .r_addr      (i_r_addr[r]),
      .stored_data (stored_data),
      .stored_pend (stored_pend),
      .w_en_ext    (w_en_ext),
      .w_addr_ext  (w_addr_ext),
      .w_data_ext  (w_data_ext),
      .rsv_en      (i_rsv_en),
      .rsv_addr    (i_rsv_addr),
      .r_data      (o_r_data[r]),
      .r_pending   (o_r_pending[r])
    );
  end

endmodule
